// File: rtl/ase_sim_local_mem_avmm_arb_if.sv
// One Avalon-MM link: used for both AFU requester ports and the bank-side port.
interface ase_sim_local_mem_avmm_arb_if #(
  parameter int ADDR_WIDTH      = 27,
  parameter int DATA_WIDTH      = 512,
  parameter int BURST_CNT_WIDTH = 7
);
  logic                       waitrequest;
  logic                       read;
  logic                       write;
  logic [ADDR_WIDTH-1:0]      address;
  logic [BURST_CNT_WIDTH-1:0] burstcount;
  logic [DATA_WIDTH-1:0]      writedata;
  logic [DATA_WIDTH/8-1:0]    byteenable;
  logic [DATA_WIDTH-1:0]      readdata;
  logic                       readdatavalid;

  modport master (
    input  waitrequest, readdata, readdatavalid,
    output read, write, address, burstcount, writedata, byteenable
  );

  modport slave (
    output waitrequest, readdata, readdatavalid,
    input  read, write, address, burstcount, writedata, byteenable
  );
endinterface

// File: rtl/ase_sim_local_mem_avmm_arb.sv
// Two-requester Avalon-MM arbiter for one local-memory bank: zero-latency command
// forwarding, write-burst grant lock, in-order read response steering via a tag FIFO.
module ase_sim_local_mem_avmm_arb #(
  parameter int ADDR_WIDTH      = 27,
  parameter int DATA_WIDTH      = 512,
  parameter int BURST_CNT_WIDTH = 7,
  parameter int RSP_FIFO_DEPTH  = 16
) (
  input  logic                                clk,
  input  logic                                reset,
  ase_sim_local_mem_avmm_arb_if.slave         s0,
  ase_sim_local_mem_avmm_arb_if.slave         s1,
  ase_sim_local_mem_avmm_arb_if.master        m,
  output logic                                err_unexpected_rsp
);
  localparam int PTR_W = (RSP_FIFO_DEPTH > 1) ? $clog2(RSP_FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(RSP_FIFO_DEPTH + 1);

  typedef enum logic [0:0] {IDLE, WR_BURST} state_t;

  state_t                     state_q;
  logic                       last_grant_q;
  logic                       lock_port_q;
  logic [BURST_CNT_WIDTH-1:0] beats_left_q;
  logic [PTR_W-1:0]           wr_ptr_q;
  logic [PTR_W-1:0]           rd_ptr_q;
  logic [CNT_W-1:0]           count_q;
  logic [BURST_CNT_WIDTH-1:0] rsp_left_q;
  logic                       err_q;

  logic                       fifo_port_mem [RSP_FIFO_DEPTH];
  logic [BURST_CNT_WIDTH-1:0] fifo_bc_mem   [RSP_FIFO_DEPTH];

  logic                         gnt_port, gnt_any;
  logic                         g_read, g_write, g_stall;
  logic [ADDR_WIDTH-1:0]        g_address;
  logic [BURST_CNT_WIDTH-1:0]   g_burstcount;
  logic [DATA_WIDTH-1:0]        g_writedata;
  logic [DATA_WIDTH/8-1:0]      g_byteenable;
  logic                         fifo_full, fifo_empty;
  logic                         rd_accept, wr_accept;
  logic                         head_port, rsp_valid, pop;
  logic [BURST_CNT_WIDTH-1:0]   head_bc, cur_left;

  // Grant is combinational in IDLE and pinned to the burst owner in WR_BURST.
  always_comb begin
    gnt_port = 1'b0;
    gnt_any  = 1'b0;
    if (state_q == WR_BURST) begin
      gnt_port = lock_port_q;
      gnt_any  = 1'b1;
    end else if ((s0.read || s0.write) && (s1.read || s1.write)) begin
      gnt_port = ~last_grant_q;
      gnt_any  = 1'b1;
    end else if (s0.read || s0.write) begin
      gnt_port = 1'b0;
      gnt_any  = 1'b1;
    end else if (s1.read || s1.write) begin
      gnt_port = 1'b1;
      gnt_any  = 1'b1;
    end
  end

  always_comb begin
    g_read       = gnt_port ? s1.read       : s0.read;
    g_write      = gnt_port ? s1.write      : s0.write;
    g_address    = gnt_port ? s1.address    : s0.address;
    g_burstcount = gnt_port ? s1.burstcount : s0.burstcount;
    g_writedata  = gnt_port ? s1.writedata  : s0.writedata;
    g_byteenable = gnt_port ? s1.byteenable : s0.byteenable;
  end

  assign fifo_full  = (count_q == CNT_W'(RSP_FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign g_stall    = m.waitrequest || (g_read && fifo_full);

  assign m.read       = !reset && gnt_any && g_read && !fifo_full;
  assign m.write      = !reset && gnt_any && g_write;
  assign m.address    = g_address;
  assign m.burstcount = g_burstcount;
  assign m.writedata  = g_writedata;
  assign m.byteenable = g_byteenable;

  assign s0.waitrequest = reset || !gnt_any || gnt_port  || g_stall;
  assign s1.waitrequest = reset || !gnt_any || !gnt_port || g_stall;

  assign rd_accept = m.read  && !m.waitrequest;
  assign wr_accept = m.write && !m.waitrequest;

  // rsp_left_q == 0 means the head entry has not delivered any beat yet.
  assign head_port = fifo_port_mem[rd_ptr_q];
  assign head_bc   = fifo_bc_mem[rd_ptr_q];
  assign cur_left  = (rsp_left_q == '0) ? head_bc : rsp_left_q;
  assign rsp_valid = m.readdatavalid && !fifo_empty;
  assign pop       = rsp_valid && (cur_left == BURST_CNT_WIDTH'(1));

  assign s0.readdata      = m.readdata;
  assign s1.readdata      = m.readdata;
  assign s0.readdatavalid = rsp_valid && !head_port;
  assign s1.readdatavalid = rsp_valid && head_port;

  assign err_unexpected_rsp = err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      lock_port_q  <= 1'b0;
      beats_left_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      rsp_left_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (wr_accept) begin
            if (g_burstcount > BURST_CNT_WIDTH'(1)) begin
              state_q      <= WR_BURST;
              lock_port_q  <= gnt_port;
              beats_left_q <= g_burstcount - BURST_CNT_WIDTH'(1);
            end else begin
              last_grant_q <= gnt_port;
            end
          end
        end
        WR_BURST: begin
          if (wr_accept) begin
            beats_left_q <= beats_left_q - BURST_CNT_WIDTH'(1);
            if (beats_left_q == BURST_CNT_WIDTH'(1)) begin
              state_q      <= IDLE;
              last_grant_q <= lock_port_q;
            end
          end
        end
        default: state_q <= IDLE;
      endcase

      if (rd_accept) begin
        last_grant_q <= gnt_port;
        wr_ptr_q     <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (rd_accept && !pop)      count_q <= count_q + CNT_W'(1);
      else if (pop && !rd_accept) count_q <= count_q - CNT_W'(1);

      if (rsp_valid) rsp_left_q <= pop ? '0 : (cur_left - BURST_CNT_WIDTH'(1));
      if (m.readdatavalid && fifo_empty) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_accept) begin
      fifo_port_mem[wr_ptr_q] <= gnt_port;
      fifo_bc_mem[wr_ptr_q]   <= g_burstcount;
    end
  end
endmodule

// File: tb/tb_ase_sim_local_mem_avmm_arb.sv
// Bench for the two-port local-memory arbiter: directed scenarios plus a randomized
// run checked against a queue-based reference model.
module tb_ase_sim_local_mem_avmm_arb;
  localparam int AW = 27;
  localparam int DW = 512;
  localparam int BW = 7;
  localparam int DEPTH = 16;
  localparam logic [AW-1:0] A0 = 27'h0000100;
  localparam logic [AW-1:0] A1 = 27'h4000100;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic err_unexpected_rsp;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  ase_sim_local_mem_avmm_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_CNT_WIDTH(BW)) s0_if ();
  ase_sim_local_mem_avmm_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_CNT_WIDTH(BW)) s1_if ();
  ase_sim_local_mem_avmm_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_CNT_WIDTH(BW)) m_if ();

  ase_sim_local_mem_avmm_arb #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_CNT_WIDTH(BW), .RSP_FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .s0(s0_if),
    .s1(s1_if),
    .m(m_if),
    .err_unexpected_rsp(err_unexpected_rsp)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic drive_port(input int p, input logic rd, input logic wr, input logic [AW-1:0] a,
                            input logic [BW-1:0] bc, input logic [DW-1:0] d);
    if (p == 0) begin
      s0_if.read = rd; s0_if.write = wr; s0_if.address = a;
      s0_if.burstcount = bc; s0_if.writedata = d; s0_if.byteenable = '1;
    end else begin
      s1_if.read = rd; s1_if.write = wr; s1_if.address = a;
      s1_if.burstcount = bc; s1_if.writedata = d; s1_if.byteenable = '1;
    end
  endtask

  task automatic idle_all();
    drive_port(0, 1'b0, 1'b0, A0, 7'd1, '0);
    drive_port(1, 1'b0, 1'b0, A1, 7'd1, '0);
    m_if.waitrequest = 1'b0;
    m_if.readdatavalid = 1'b0;
    m_if.readdata = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #1 reset = 1'b1;
    idle_all();
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    logic [1:0] v;
    #1 reset = 1'b1;
    idle_all();
    s0_if.read = 1'b1; s1_if.write = 1'b1; m_if.readdatavalid = 1'b1;
    #2;
    v = {m_if.read, m_if.write};
    total_cnt++;
    if (v !== 2'b00) $display("FAIL reset_cmd: got %b expected 00", v); else pass_cnt++;
    v = {s0_if.waitrequest, s1_if.waitrequest};
    total_cnt++;
    if (v !== 2'b11) $display("FAIL reset_wait: got %b expected 11", v); else pass_cnt++;
    v = {s0_if.readdatavalid, s1_if.readdatavalid};
    total_cnt++;
    if (v !== 2'b00) $display("FAIL reset_rdv: got %b expected 00", v); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (err_unexpected_rsp !== 1'b0) $display("FAIL reset_err: got %b expected 0", err_unexpected_rsp);
    else pass_cnt++;
    idle_all();
    @(posedge clk); #1 reset = 1'b0; #1;
    s0_if.read = 1'b1; s1_if.read = 1'b1; #1;
    total_cnt++;
    if (m_if.read !== 1'b1 || m_if.address !== A0)
      $display("FAIL first_tie: got read=%b addr=%h expected read=1 addr=%h", m_if.read, m_if.address, A0);
    else pass_cnt++;
    s0_if.read = 1'b0; s1_if.read = 1'b0;
  endtask

  task automatic test_read_burst();
    logic [DW-1:0] d;
    logic [AW+BW+1:0] v;
    idle_all();
    drive_port(0, 1'b1, 1'b0, 27'h100, 7'd4, '0);
    #1;
    v = {m_if.read, m_if.address, m_if.burstcount, s0_if.waitrequest};
    total_cnt++;
    if (v !== {1'b1, 27'h100, 7'd4, 1'b0}) $display("FAIL rd4_cmd: got %h expected %h", v, {1'b1, 27'h100, 7'd4, 1'b0});
    else pass_cnt++;
    next_cycle();
    s0_if.read = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d = rnd_data();
      m_if.readdata = d; m_if.readdatavalid = 1'b1; #1;
      total_cnt++;
      if ({s0_if.readdatavalid, s1_if.readdatavalid} !== 2'b10)
        $display("FAIL rd4_rdv beat %0d: got %b expected 10", i, {s0_if.readdatavalid, s1_if.readdatavalid});
      else pass_cnt++;
      total_cnt++;
      if (s0_if.readdata !== d) $display("FAIL rd4_data beat %0d: got %h expected %h", i, s0_if.readdata[31:0], d[31:0]);
      else pass_cnt++;
      next_cycle();
    end
    m_if.readdatavalid = 1'b0; #1;
    total_cnt++;
    if ({s0_if.readdatavalid, s1_if.readdatavalid, err_unexpected_rsp} !== 3'b000)
      $display("FAIL rd4_after: got %b expected 000", {s0_if.readdatavalid, s1_if.readdatavalid, err_unexpected_rsp});
    else pass_cnt++;
  endtask

  task automatic test_alternation();
    logic [1:0] v;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive_port(0, 1'b0, 1'b1, A0, 7'd1, DW'(i));
      drive_port(1, 1'b0, 1'b1, A1, 7'd1, DW'(i));
      #1;
      v = {m_if.write, (m_if.address == A1)};
      total_cnt++;
      if (v !== {1'b1, 1'(i % 2)}) $display("FAIL alt_order %0d: got %b expected %b", i, v, {1'b1, 1'(i % 2)});
      else pass_cnt++;
      next_cycle();
    end
    idle_all();
  endtask

  task automatic test_write_burst_lock();
    int beat = 0;
    int cyc = 0;
    bit stalled = 1'b0;
    logic [3:0] v;
    idle_all();
    while (beat < 8 && cyc < 20) begin
      drive_port(1, 1'b0, 1'b1, A1, 7'd8, DW'(beat));
      drive_port(0, (beat >= 1), 1'b0, A0, 7'd1, '0);
      m_if.waitrequest = (beat == 4) && !stalled;
      #1;
      v = {m_if.write, m_if.read, s0_if.waitrequest, s1_if.waitrequest};
      total_cnt++;
      if (v !== {3'b101, m_if.waitrequest} || m_if.writedata !== DW'(beat))
        $display("FAIL burst_beat %0d: got ctl=%b data=%0h expected ctl=%b data=%0h",
                 beat, v, m_if.writedata[15:0], {3'b101, m_if.waitrequest}, beat);
      else pass_cnt++;
      if (m_if.waitrequest) stalled = 1'b1; else beat++;
      next_cycle();
      cyc++;
    end
    total_cnt++;
    if (beat != 8) $display("FAIL burst_budget: got %0d beats expected 8", beat); else pass_cnt++;
    s1_if.write = 1'b0; m_if.waitrequest = 1'b0; #1;
    v = {m_if.read, (m_if.address == A0), s0_if.waitrequest, m_if.write};
    total_cnt++;
    if (v !== 4'b1100) $display("FAIL rd_after_burst: got %b expected 1100", v); else pass_cnt++;
    next_cycle();
    s0_if.read = 1'b0; m_if.readdatavalid = 1'b1; #1;
    total_cnt++;
    if ({s0_if.readdatavalid, s1_if.readdatavalid} !== 2'b10)
      $display("FAIL burst_rd_rsp: got %b expected 10", {s0_if.readdatavalid, s1_if.readdatavalid});
    else pass_cnt++;
    next_cycle();
    m_if.readdatavalid = 1'b0;
  endtask

  task automatic test_fifo_full();
    int exp_q[$];
    int got = 0;
    int cyc = 0;
    logic [2:0] v;
    logic [1:0] e;
    idle_all();
    for (int i = 0; i < 16; i++) begin
      drive_port(i % 2, 1'b1, 1'b0, (i % 2) ? A1 : A0, 7'd1, '0);
      #1;
      total_cnt++;
      if (m_if.read !== 1'b1) $display("FAIL fill_read %0d: got %b expected 1", i, m_if.read); else pass_cnt++;
      exp_q.push_back(i % 2);
      next_cycle();
      idle_all();
    end
    s1_if.read = 1'b1; #1;
    total_cnt++;
    if ({s1_if.waitrequest, m_if.read} !== 2'b10)
      $display("FAIL full_stall: got %b expected 10", {s1_if.waitrequest, m_if.read});
    else pass_cnt++;
    next_cycle();
    drive_port(0, 1'b0, 1'b1, A0, 7'd1, '0); #1;
    v = {m_if.write, s0_if.waitrequest, m_if.read};
    total_cnt++;
    if (v !== 3'b100 || m_if.address !== A0) $display("FAIL full_write: got %b expected 100", v); else pass_cnt++;
    next_cycle();
    idle_all();
    while (got < 16 && cyc < 100) begin
      m_if.readdatavalid = ($urandom_range(0, 2) != 0);
      #1;
      e = 2'b00;
      if (m_if.readdatavalid) e = (exp_q[0] == 1) ? 2'b01 : 2'b10;
      total_cnt++;
      if ({s0_if.readdatavalid, s1_if.readdatavalid} !== e)
        $display("FAIL full_route %0d: got %b expected %b", got, {s0_if.readdatavalid, s1_if.readdatavalid}, e);
      else pass_cnt++;
      if (m_if.readdatavalid) begin
        void'(exp_q.pop_front());
        got++;
      end
      next_cycle();
      cyc++;
    end
    m_if.readdatavalid = 1'b0;
    total_cnt++;
    if (got != 16) $display("FAIL full_drain_budget: got %0d expected 16", got); else pass_cnt++;
  endtask

  task automatic test_reset_midburst();
    logic [3:0] v;
    idle_all();
    for (int i = 0; i < 2; i++) begin
      drive_port(1, 1'b1, 1'b0, A1, 7'd1, '0);
      next_cycle();
    end
    idle_all();
    for (int b = 0; b < 2; b++) begin
      drive_port(0, 1'b0, 1'b1, A0, 7'd8, DW'(b));
      next_cycle();
    end
    drive_port(0, 1'b0, 1'b1, A0, 7'd8, DW'(2));
    #1 reset = 1'b1; #1;
    v = {m_if.read, m_if.write, s0_if.waitrequest, s1_if.waitrequest};
    total_cnt++;
    if (v !== 4'b0011) $display("FAIL midburst_reset_out: got %b expected 0011", v); else pass_cnt++;
    @(posedge clk); #1;
    idle_all();
    reset = 1'b0; #1;
    total_cnt++;
    if (err_unexpected_rsp !== 1'b0) $display("FAIL midburst_err_clr: got %b expected 0", err_unexpected_rsp);
    else pass_cnt++;
    m_if.readdatavalid = 1'b1; #1;
    total_cnt++;
    if ({s0_if.readdatavalid, s1_if.readdatavalid} !== 2'b00)
      $display("FAIL stray_rdv: got %b expected 00", {s0_if.readdatavalid, s1_if.readdatavalid});
    else pass_cnt++;
    next_cycle();
    m_if.readdatavalid = 1'b0;
    next_cycle();
    total_cnt++;
    if (err_unexpected_rsp !== 1'b1) $display("FAIL stray_err_sticky: got %b expected 1", err_unexpected_rsp);
    else pass_cnt++;
    do_reset();
    total_cnt++;
    if (err_unexpected_rsp !== 1'b0) $display("FAIL err_reset_clear: got %b expected 0", err_unexpected_rsp);
    else pass_cnt++;
  endtask

  task automatic test_push_pop_same();
    int exp_q[$];
    int got = 0;
    int cyc = 0;
    logic [3:0] v;
    logic [1:0] e;
    do_reset();
    for (int i = 0; i < 15; i++) begin
      drive_port(i % 2, 1'b1, 1'b0, (i % 2) ? A1 : A0, 7'd1, '0);
      exp_q.push_back(i % 2);
      next_cycle();
      idle_all();
    end
    drive_port(1, 1'b1, 1'b0, A1, 7'd1, '0);
    m_if.readdatavalid = 1'b1; #1;
    v = {s1_if.waitrequest, m_if.read, s0_if.readdatavalid, s1_if.readdatavalid};
    total_cnt++;
    if (v !== 4'b0110) $display("FAIL push_pop_same: got %b expected 0110", v); else pass_cnt++;
    void'(exp_q.pop_front());
    exp_q.push_back(1);
    next_cycle();
    idle_all();
    drive_port(0, 1'b1, 1'b0, A0, 7'd1, '0); #1;
    total_cnt++;
    if ({s0_if.waitrequest, m_if.read} !== 2'b01)
      $display("FAIL occupancy_15: got %b expected 01", {s0_if.waitrequest, m_if.read});
    else pass_cnt++;
    exp_q.push_back(0);
    next_cycle();
    idle_all();
    drive_port(1, 1'b1, 1'b0, A1, 7'd1, '0); #1;
    total_cnt++;
    if ({s1_if.waitrequest, m_if.read} !== 2'b10)
      $display("FAIL occupancy_16: got %b expected 10", {s1_if.waitrequest, m_if.read});
    else pass_cnt++;
    idle_all();
    while (got < 16 && cyc < 100) begin
      m_if.readdatavalid = ($urandom_range(0, 3) != 0);
      #1;
      e = 2'b00;
      if (m_if.readdatavalid) e = (exp_q[0] == 1) ? 2'b01 : 2'b10;
      total_cnt++;
      if ({s0_if.readdatavalid, s1_if.readdatavalid} !== e)
        $display("FAIL pp_route %0d: got %b expected %b", got, {s0_if.readdatavalid, s1_if.readdatavalid}, e);
      else pass_cnt++;
      if (m_if.readdatavalid) begin
        void'(exp_q.pop_front());
        got++;
      end
      next_cycle();
      cyc++;
    end
    m_if.readdatavalid = 1'b0;
    total_cnt++;
    if (got != 16 || err_unexpected_rsp !== 1'b0)
      $display("FAIL pp_drain: got %0d beats err=%b expected 16 err=0", got, err_unexpected_rsp);
    else pass_cnt++;
  endtask

  task automatic test_random();
    int mdl_last, mdl_lock, mdl_left, g, r;
    int cmd_q[$];
    int beats_q[$];
    logic [AW-1:0] a_drv [2];
    logic [BW-1:0] bc_drv [2];
    logic prd, pwr, g_rd, g_wr, full, e_rd, e_wr, stall, rsp;
    logic [5:0] exp_v, got_v;
    do_reset();
    mdl_last = 1; mdl_lock = -1; mdl_left = 0;
    for (int c = 0; c < 1000; c++) begin
      if (c >= 400 && cmd_q.size() == 0) break;
      idle_all();
      a_drv[0] = A0; a_drv[1] = A1; bc_drv[0] = 7'd1; bc_drv[1] = 7'd1;
      if (c < 400) begin
        for (int p = 0; p < 2; p++) begin
          prd = 1'b0; pwr = 1'b0;
          r = $urandom_range(0, 9);
          if (mdl_lock == p) pwr = (r < 8);
          else if (r < 4) prd = 1'b1;
          else if (r < 7) pwr = 1'b1;
          bc_drv[p] = prd ? BW'($urandom_range(1, 3)) : BW'($urandom_range(1, 4));
          a_drv[p] = {p[0], 26'($urandom)};
          drive_port(p, prd, pwr, a_drv[p], bc_drv[p], rnd_data());
        end
        m_if.waitrequest = ($urandom_range(0, 3) == 0);
        m_if.readdatavalid = (cmd_q.size() > 0) && ($urandom_range(0, 1) == 1);
      end else begin
        m_if.readdatavalid = 1'b1;
      end
      m_if.readdata = rnd_data();
      #1;
      if (mdl_lock >= 0) g = mdl_lock;
      else if ((s0_if.read || s0_if.write) && (s1_if.read || s1_if.write)) g = 1 - mdl_last;
      else if (s0_if.read || s0_if.write) g = 0;
      else if (s1_if.read || s1_if.write) g = 1;
      else g = -1;
      g_rd = (g == 0) ? s0_if.read  : (g == 1) ? s1_if.read  : 1'b0;
      g_wr = (g == 0) ? s0_if.write : (g == 1) ? s1_if.write : 1'b0;
      full = (cmd_q.size() == DEPTH);
      e_rd = g_rd && !full;
      e_wr = g_wr;
      stall = m_if.waitrequest || (g_rd && full);
      rsp = m_if.readdatavalid && (cmd_q.size() > 0);
      exp_v = {e_rd, e_wr, (g != 0) || stall, (g != 1) || stall,
               rsp && (cmd_q[0] == 0), rsp && (cmd_q[0] == 1)};
      got_v = {m_if.read, m_if.write, s0_if.waitrequest, s1_if.waitrequest,
               s0_if.readdatavalid, s1_if.readdatavalid};
      total_cnt++;
      if (got_v !== exp_v) $display("FAIL rnd_ctl cycle %0d: got %b expected %b", c, got_v, exp_v);
      else pass_cnt++;
      if (e_rd || e_wr) begin
        total_cnt++;
        if ({m_if.address, m_if.burstcount} !== {a_drv[g], bc_drv[g]})
          $display("FAIL rnd_cmd cycle %0d: got %h/%0d expected %h/%0d", c, m_if.address, m_if.burstcount,
                   a_drv[g], bc_drv[g]);
        else pass_cnt++;
      end
      if (e_wr && !m_if.waitrequest) begin
        if (mdl_lock < 0) begin
          if (bc_drv[g] > 1) begin
            mdl_lock = g;
            mdl_left = int'(bc_drv[g]) - 1;
          end else mdl_last = g;
        end else begin
          mdl_left--;
          if (mdl_left == 0) begin
            mdl_last = mdl_lock;
            mdl_lock = -1;
          end
        end
      end
      if (rsp) begin
        beats_q[0] = beats_q[0] - 1;
        if (beats_q[0] == 0) begin
          void'(cmd_q.pop_front());
          void'(beats_q.pop_front());
        end
      end
      if (e_rd && !m_if.waitrequest) begin
        cmd_q.push_back(g);
        beats_q.push_back(int'(bc_drv[g]));
        mdl_last = g;
      end
      next_cycle();
    end
    idle_all();
    total_cnt++;
    if (cmd_q.size() != 0 || err_unexpected_rsp !== 1'b0)
      $display("FAIL rnd_drain: got %0d pending err=%b expected 0 pending err=0", cmd_q.size(), err_unexpected_rsp);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_read_burst();
    test_alternation();
    test_write_burst_lock();
    test_fifo_full();
    test_reset_midburst();
    test_push_pop_same();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/ase_sim_local_mem_avmm_arb.md
Name: ase_sim_local_mem_avmm_arb

Overview:
Two-requester Avalon-MM arbiter that shares one simulated local-memory bank between two AFU-side masters. It sits between the AFU ports and one bank's bridge/emulator master port. It forwards commands with zero added latency and locks the grant for the full length of a write burst. Read responses are steered back to the issuing requester through an in-order tag FIFO.

Parameters:
ADDR_WIDTH, 27, word address width
DATA_WIDTH, 512, data width in bits; byteenable width is DATA_WIDTH/8
BURST_CNT_WIDTH, 7, burstcount width
RSP_FIFO_DEPTH, 16, maximum outstanding read commands (power of 2)

Ports:
clk  in  1  bank clock; sole clock
reset  in  1  asynchronous, active-high
sN_waitrequest  out  1  per requester N=0,1; stall for that requester
sN_read / sN_write  in  1  command strobes; never both high
sN_address  in  ADDR_WIDTH  word address
sN_burstcount  in  BURST_CNT_WIDTH  beats; 0 is illegal
sN_writedata  in  DATA_WIDTH  write beat
sN_byteenable  in  DATA_WIDTH/8  byte mask
sN_readdata  out  DATA_WIDTH  equals m_readdata, driven to both requesters
sN_readdatavalid  out  1  response beat belongs to N
m_waitrequest  in  1  bank stall
m_read / m_write / m_address / m_burstcount / m_writedata / m_byteenable  out  as above  muxed command
m_readdata  in  DATA_WIDTH; m_readdatavalid  in  1  bank response
err_unexpected_rsp  out  1  sticky: response arrived with FIFO empty

Behaviour:
- Reset (async assert): state IDLE, last_grant=1 so port 0 wins the first tie, FIFO empty, err_unexpected_rsp=0. While reset is high, m_read=m_write=0 and both sN_waitrequest=1.
- States:
  - IDLE: grant is combinational. A requester is eligible if its read or write is asserted. With one eligible, it wins. With both eligible, the port other than last_grant wins.
  - WR_BURST: grant is held on the locked port. The other port sees waitrequest=1.
- Forwarding: m_* carries the granted port's command the same cycle (0-cycle latency).
  - m_read = granted sN_read && !fifo_full.
  - m_write = granted sN_write.
- Waitrequest:
  - Granted port: sN_waitrequest = m_waitrequest || (sN_read && fifo_full).
  - Ungranted port: sN_waitrequest = 1.
- Write accept (m_write && !m_waitrequest):
  - In IDLE with burstcount>1: lock the port, beats_left = burstcount-1, go to WR_BURST.
  - In IDLE with burstcount=1: last_grant = port.
- WR_BURST: each accepted beat decrements beats_left. When the beat with beats_left==1 is accepted, go to IDLE and set last_grant = port. A stalled beat holds the state.
- Read accept (m_read && !m_waitrequest): push {port, burstcount} into the FIFO and set last_grant = port. Read is legal only in IDLE.
- Response routing:
  - On m_readdatavalid, assert sN_readdatavalid for N = head.port.
  - rsp_left counts down from head.burstcount. Pop the FIFO on the last beat.
  - A push and a pop in the same cycle are both honoured; count is unchanged.
  - FIFO full blocks only reads. Writes still proceed.
- m_readdatavalid with the FIFO empty: no sN_readdatavalid is asserted, err_unexpected_rsp sets, and it clears only on reset.
- Reset mid-burst or with reads outstanding: return to IDLE, flush the FIFO, drop any later stray responses (these also set err).
- Burstcount arithmetic is unsigned BURST_CNT_WIDTH. Max burst 2^BURST_CNT_WIDTH-1 needs no wrap.

Test Plan:
- Port0 single read of burst 4 at 0x100, bank returns 4 beats → s0_readdatavalid for 4 cycles, s1_readdatavalid stays 0.
- Both ports issue a 1-beat write each cycle for 4 cycles → accepted order is 0,1,0,1.
- Port1 write burst 8 while port0 requests a read at beat 2, with m_waitrequest pulsed on beat 5 → all 8 port1 beats are contiguous, port0 read is issued next cycle after beat 8, beats_left holds during the stall.
- 16 outstanding 1-beat reads alternating ports, bank stalls responses → 17th read sees waitrequest=1 while a port0 write is still accepted; responses route to 0,1,0,1…
- Reset asserted with a write at beat 3 of 8 and 2 reads outstanding → outputs idle immediately; after release, a response beat sets err_unexpected_rsp=1 and no readdatavalid is raised.
- Read push and last-beat pop in the same cycle with the FIFO at 15 entries → occupancy stays 15 and the next read is not stalled.
